mcp4921_dac_writer: RTL and testbench

SPI write engine for the Microchip MCP4921 12-bit DAC: the transmit-side counterpart of the MCP3002 ADC reader on the same board. It accepts one 12-bit sample per valid/ready handshake, shifts a 16-bit command word to the DAC in SPI mode 0, then pulses LDAC to latch the output. It sits between the OFDM sample path and the DAC pins.

---
 rtl/mcp4921_dac_writer_if.sv | 10 +
 rtl/mcp4921_dac_writer.sv | 159 +++++++++++++++
 tb/tb_mcp4921_dac_writer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcp4921_dac_writer_if.sv
// rtl/mcp4921_dac_writer_if.sv - sample handshake bundle between the sample path and the DAC writer
interface mcp4921_dac_writer_if;
  logic [11:0] data;
  logic        valid;
  logic        ready;
  logic        done;

  modport master (output data, output valid, input ready, input done);
  modport slave  (input data, input valid, output ready, output done);
endinterface

// File: rtl/mcp4921_dac_writer.sv
// rtl/mcp4921_dac_writer.sv - MCP4921 SPI mode-0 write engine with LDAC latch strobe
module mcp4921_dac_writer #(
  parameter int   CLK_FREQ         = 27_000_000,
  parameter int   MCP4921_CLK_FREQ = 1_350_000,
  parameter logic BUF              = 1'b0,
  parameter logic GA_N             = 1'b1,
  parameter logic SHDN_N           = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  mcp4921_dac_writer_if.slave   bus,
  output logic                  dac_clk,
  output logic                  dac_din,
  output logic                  cs,
  output logic                  ldac_n
);

  localparam int CYCLE = CLK_FREQ / MCP4921_CLK_FREQ;
  localparam int HALF  = CYCLE / 2;
  localparam int PW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] HALF_M1 = PW'(HALF - 1);

  generate
    if (CYCLE < 4 || (CYCLE % 2) != 0) begin : g_bad_cycle
      $error("mcp4921_dac_writer: CYCLE must be even and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP, S_LDAC} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [3:0]     bit_q, bit_d;
  logic [14:0]    sr_q, sr_d;
  logic           clk_q, clk_d;
  logic           din_q, din_d;
  logic           cs_q, cs_d;
  logic           ldac_q, ldac_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic [15:0]    frame;
  logic           phase_end;

  assign frame     = {1'b0, BUF, GA_N, SHDN_N, bus.data};
  assign phase_end = (phase_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      clk_q   <= 1'b0;
      din_q   <= 1'b0;
      cs_q    <= 1'b1;
      ldac_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      clk_q   <= clk_d;
      din_q   <= din_d;
      cs_q    <= cs_d;
      ldac_q  <= ldac_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    clk_d   = clk_q;
    din_d   = din_q;
    cs_d    = cs_q;
    ldac_d  = ldac_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.valid && ready_q) begin
          sr_d    = frame[14:0];
          din_d   = frame[15];
          cs_d    = 1'b0;
          phase_d = HALF_M1;
          bit_d   = 4'd15;
          ready_d = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!phase_end) begin
          phase_d = phase_q - 1'b1;
        end else begin
          phase_d = HALF_M1;
          if (!clk_q) begin
            clk_d = 1'b1;
          end else begin
            // Falling edge of SCK: the DAC already sampled, so advance SDI here.
            clk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q - 1'b1;
              din_d = sr_q[14];
              sr_d  = {sr_q[13:0], 1'b0};
            end
          end
        end
      end
      S_HOLD: begin
        if (!phase_end) begin
          phase_d = phase_q - 1'b1;
        end else begin
          phase_d = HALF_M1;
          cs_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (!phase_end) begin
          phase_d = phase_q - 1'b1;
        end else begin
          phase_d = HALF_M1;
          ldac_d  = 1'b0;
          state_d = S_LDAC;
        end
      end
      S_LDAC: begin
        if (!phase_end) begin
          phase_d = phase_q - 1'b1;
        end else begin
          phase_d = '0;
          ldac_d  = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dac_clk   = clk_q;
  assign dac_din   = din_q;
  assign cs        = cs_q;
  assign ldac_n    = ldac_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mcp4921_dac_writer.sv
// tb/tb_mcp4921_dac_writer.sv - directed self-checking bench for mcp4921_dac_writer
module tb_mcp4921_dac_writer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcp4921_dac_writer_if bus1 ();
  mcp4921_dac_writer_if bus2 ();
  logic dac_clk1, din1, cs1, ldac1;
  logic dac_clk2, din2, cs2, ldac2;

  mcp4921_dac_writer u1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1.slave),
    .dac_clk (dac_clk1),
    .dac_din (din1),
    .cs      (cs1),
    .ldac_n  (ldac1)
  );

  mcp4921_dac_writer #(.SHDN_N(1'b0)) u2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2.slave),
    .dac_clk (dac_clk2),
    .dac_din (din2),
    .cs      (cs2),
    .ldac_n  (ldac2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] cap1, cap2;
  int rises1, cs_low1, ldac_low1, done_cnt1, unstable1, n_acc1;
  int rises2, done_cnt2, unstable2, n_acc2;
  int acc1 [4];
  int cs_rise1, ldac_fall1, ldac_rise1, done_cyc1;
  logic p_clk1, p_din1, p_cs1, p_ldac1, p_clk2, p_din2;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus1.valid && bus1.ready) begin
      if (n_acc1 < 4) acc1[n_acc1] = cyc;
      n_acc1 = n_acc1 + 1;
    end
    if (bus2.valid && bus2.ready) n_acc2 = n_acc2 + 1;
  end

  always @(negedge clk) begin
    if (!cs1 && !p_clk1 && dac_clk1) begin
      cap1 = {cap1[30:0], din1};
      rises1 = rises1 + 1;
    end
    if (p_clk1 && dac_clk1 && din1 !== p_din1) unstable1 = unstable1 + 1;
    if (!cs1) cs_low1 = cs_low1 + 1;
    if (!ldac1) ldac_low1 = ldac_low1 + 1;
    if (bus1.done) begin
      done_cnt1 = done_cnt1 + 1;
      done_cyc1 = cyc;
    end
    if (!p_cs1 && cs1) cs_rise1 = cyc;
    if (p_ldac1 && !ldac1) ldac_fall1 = cyc;
    if (!p_ldac1 && ldac1) ldac_rise1 = cyc;
    p_clk1 = dac_clk1; p_din1 = din1; p_cs1 = cs1; p_ldac1 = ldac1;

    if (!cs2 && !p_clk2 && dac_clk2) begin
      cap2 = {cap2[30:0], din2};
      rises2 = rises2 + 1;
    end
    if (p_clk2 && dac_clk2 && din2 !== p_din2) unstable2 = unstable2 + 1;
    if (bus2.done) done_cnt2 = done_cnt2 + 1;
    p_clk2 = dac_clk2; p_din2 = din2;
  end

  task automatic clear_mon();
    cap1 = '0; cap2 = '0;
    rises1 = 0; cs_low1 = 0; ldac_low1 = 0; done_cnt1 = 0; unstable1 = 0; n_acc1 = 0;
    rises2 = 0; done_cnt2 = 0; unstable2 = 0; n_acc2 = 0;
    cs_rise1 = -1; ldac_fall1 = -1; ldac_rise1 = -1; done_cyc1 = -1;
    for (int i = 0; i < 4; i++) acc1[i] = -1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic wait_done1(input int n, input int bound);
    int k = 0;
    while (done_cnt1 < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt1 < n) check("done1_timeout", done_cnt1, n);
  endtask

  task automatic send1(input logic [11:0] d);
    bus1.data  = d;
    bus1.valid = 1'b1;
    @(negedge clk);
    bus1.valid = 1'b0;
  endtask

  initial begin
    int k;
    clear_mon();
    rst = 1'b1;
    bus1.valid = 1'b0; bus1.data = '0;
    bus2.valid = 1'b0; bus2.data = '0;

    repeat (3) @(negedge clk);
    check("rst_cs", cs1, 1);
    check("rst_dac_clk", dac_clk1, 0);
    check("rst_dac_din", din1, 0);
    check("rst_ldac_n", ldac1, 1);
    check("rst_ready", bus1.ready, 1);
    check("rst_done", bus1.done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write of 12'hA5C
    clear_mon();
    send1(12'hA5C);
    check("accept_ready_low", bus1.ready, 0);
    wait_done1(1, 600);
    repeat (5) @(negedge clk);
    check("single_word", cap1[15:0], 32'h3A5C);
    check("single_rises", rises1, 16);
    check("single_cs_low", cs_low1, 330);
    check("cs_rise_time", cs_rise1 - acc1[0], 330);
    check("ldac_after_cs", ldac_fall1 - cs_rise1, 10);
    check("ldac_low_width", ldac_low1, 10);
    check("ldac_rise_time", ldac_rise1 - acc1[0], 350);
    check("done_width", done_cnt1, 1);
    check("done_at_ldac_rise", done_cyc1, ldac_rise1);
    check("ready_after", bus1.ready, 1);
    check("single_accepts", n_acc1, 1);
    check("single_sdi_stable", unstable1, 0);

    // Busy rejection: a mid-frame valid pulse is dropped
    clear_mon();
    send1(12'hA5C);
    repeat (50) @(negedge clk);
    send1(12'h123);
    wait_done1(1, 600);
    repeat (20) @(negedge clk);
    check("busy_word", cap1[15:0], 32'h3A5C);
    check("busy_accepts", n_acc1, 1);
    check("busy_rises", rises1, 16);

    // Back-to-back: valid held, data changed after the first accept
    clear_mon();
    bus1.data = 12'hA5C;
    bus1.valid = 1'b1;
    @(negedge clk);
    bus1.data = 12'h123;
    k = 0;
    while (n_acc1 < 2 && k < 800) begin
      @(negedge clk);
      k++;
    end
    bus1.valid = 1'b0;
    check("b2b_accepts", n_acc1, 2);
    check("b2b_spacing", acc1[1] - acc1[0], 351);
    wait_done1(2, 600);
    repeat (5) @(negedge clk);
    check("b2b_words", cap1, 32'h3A5C3123);
    check("b2b_rises", rises1, 32);

    // Reset at edge 100 of a frame
    clear_mon();
    send1(12'hA5C);
    k = 0;
    while (cyc != acc1[0] + 99 && k < 200) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs", cs1, 1);
    check("midrst_dac_clk", dac_clk1, 0);
    check("midrst_ldac_n", ldac1, 1);
    check("midrst_ready", bus1.ready, 1);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("midrst_no_ldac", ldac_low1, 0);
    check("midrst_no_done", done_cnt1, 0);
    clear_mon();
    send1(12'h000);
    wait_done1(1, 600);
    repeat (3) @(negedge clk);
    check("post_rst_word", cap1[15:0], 32'h3000);
    check("post_rst_rises", rises1, 16);
    check("post_rst_stable", unstable1, 0);

    // SHDN_N=0 corner on the second instance
    clear_mon();
    bus2.data = 12'hFFF;
    bus2.valid = 1'b1;
    @(negedge clk);
    bus2.valid = 1'b0;
    k = 0;
    while (done_cnt2 < 1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("shdn_done", done_cnt2, 1);
    check("shdn_word", cap2[15:0], 32'h2FFF);
    check("shdn_rises", rises2, 16);
    check("shdn_sdi_stable", unstable2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
